// File: rtl/data_sram_responder.sv
// Single-outstanding SRAM-style data responder with a fixed response delay.
// Define DSRAM_RAND_DELAY_EN to draw a per-transaction delay of 1..4 from an 8-bit LFSR instead.
module data_sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RESP_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [CW-1:0]         delay_c;

    logic [31:0] mem [WORDS];

    // Size is decoded by the master; high address bits alias and the byte offset is irrelevant.
    logic unused_bits;
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

`ifdef DSRAM_RAND_DELAY_EN
    localparam int unsigned unused_resp_delay = RESP_DELAY;

    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign delay_c = CW'(lfsr_q[1:0]) + CW'(1);
`else
    assign delay_c = CW'(RESP_DELAY);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wstrb_q <= wstrb_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state, request capture and handshake outputs.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        wr_d              = wr_q;
        wstrb_d           = wstrb_q;
        idx_d             = idx_q;
        wdata_d           = wdata_q;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;

        case (state_q)
            IDLE: begin
                data_sram_addr_ok = data_sram_req;
                if (data_sram_req) begin
                    wr_d    = data_sram_wr;
                    wstrb_d = data_sram_wstrb;
                    idx_d   = data_sram_addr[DEPTH_LOG2+1:2];
                    wdata_d = data_sram_wdata;
                    if (delay_c <= CW'(1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = delay_c - CW'(1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end
            end
            RESP: begin
                data_sram_data_ok = 1'b1;
                if (!wr_q) begin
                    data_sram_rdata = mem[idx_q];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write commits on the edge that ends RESP; a reset in flight drops it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: main instance with RESP_DELAY=3, side instance with delay 1.
// With DSRAM_RAND_DELAY_EN defined, latencies are checked against an LFSR model instead.
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        req1, wr1;
    logic [3:0]  wstrb1;
    logic [31:0] addr1, wdata1;
    logic        addr_ok1, data_ok1;
    logic [31:0] rdata1;

    int errors = 0;
    int checks = 0;

    data_sram_responder #(.DEPTH_LOG2(10), .RESP_DELAY(3)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata)
    );

    data_sram_responder #(.DEPTH_LOG2(10), .RESP_DELAY(1)) u_dut1 (
        .clk               (clk),
        .rst               (rst),
        .data_sram_req     (req1),
        .data_sram_wr      (wr1),
        .data_sram_size    (2'd2),
        .data_sram_wstrb   (wstrb1),
        .data_sram_addr    (addr1),
        .data_sram_wdata   (wdata1),
        .data_sram_addr_ok (addr_ok1),
        .data_sram_data_ok (data_ok1),
        .data_sram_rdata   (rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DSRAM_RAND_DELAY_EN
    logic [7:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
`endif

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the main instance; entered and left at a negedge in IDLE.
    task automatic txn(input logic t_wr, input logic [3:0] t_strb, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input logic [31:0] t_exp, input int t_lat,
                       input string tag);
        int  lat;
        bit  got;
        int  exp_lat;
        exp_lat = t_lat;
`ifdef DSRAM_RAND_DELAY_EN
        exp_lat = 1 + int'(lfsr_m[1:0]);
`endif
        req = 1'b1; wr = t_wr; wstrb = t_strb; addr = t_addr; wdata = t_wdata; size = 2'd2;
        #1 check32({tag, ".addr_ok"}, 32'(addr_ok), 32'd1);
        @(posedge clk);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (data_ok === 1'b1) begin
                got = 1'b1;
                lat = k;
                check32({tag, ".rdata"}, rdata, t_exp);
                req = 1'b0;
            end else begin
                check32({tag, ".busy_addr_ok"}, 32'(addr_ok), 32'd0);
                check32({tag, ".idle_rdata"}, rdata, 32'd0);
                addr  = $urandom;
                wdata = $urandom;
                wstrb = 4'($urandom);
                wr    = ~wr;
            end
        end
        check32({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        check32({tag, ".one_shot"}, 32'(data_ok), 32'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = '0; wdata = '0;
        req1 = 1'b0; wr1 = 1'b0; wstrb1 = 4'h0; addr1 = '0; wdata1 = '0;
        #3;
        check32("rst.addr_ok", 32'(addr_ok), 32'd0);
        check32("rst.data_ok", 32'(data_ok), 32'd0);
        check32("rst.rdata", rdata, 32'd0);
        check32("rst.data_ok1", 32'(data_ok1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 3, "wr_word");
        txn(1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, 3, "rd_word");
        txn(1'b1, 4'b0100, 32'h10, 32'h00AA0000, 32'h0, 3, "wr_byte2");
        txn(1'b0, 4'b0000, 32'h12, 32'h0, 32'hDEAABEEF, 3, "rd_byte2");
        txn(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h0, 3, "wr_nop");
        txn(1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEAABEEF, 3, "rd_after_nop");
        txn(1'b1, 4'b1111, 32'h1000, 32'h11223344, 32'h0, 3, "wr_alias");
        txn(1'b0, 4'b0000, 32'h0, 32'h0, 32'h11223344, 3, "rd_alias");
        txn(1'b1, 4'b0011, 32'h0, 32'h00005678, 32'h0, 3, "wr_half");
        txn(1'b0, 4'b0000, 32'h2, 32'h0, 32'h11225678, 3, "rd_half");

`ifndef DSRAM_RAND_DELAY_EN
        // Held request: data_ok only in T+3, re-accept at T+4, second response at T+7.
        req = 1'b1; wr = 1'b0; wstrb = 4'h0; addr = 32'h10;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check32($sformatf("hold.data_ok%0d", k), 32'(data_ok), 32'(k == 3));
            check32($sformatf("hold.addr_ok%0d", k), 32'(addr_ok), 32'(k == 4));
            if (k == 3) check32("hold.rdata", rdata, 32'hDEAABEEF);
        end
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req = 1'b0;
            check32($sformatf("hold2.data_ok%0d", k), 32'(data_ok), 32'(k == 3));
            if (k == 3) check32("hold2.rdata", rdata, 32'hDEAABEEF);
        end

        // Delay-1 instance: write then immediately read back with req held.
        req1 = 1'b1; wr1 = 1'b1; wstrb1 = 4'hF; addr1 = 32'h44; wdata1 = 32'hCAFEF00D;
        #1 check32("d1.addr_ok_wr", 32'(addr_ok1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check32("d1.data_ok_wr", 32'(data_ok1), 32'd1);
        check32("d1.rdata_wr", rdata1, 32'd0);
        wr1 = 1'b0; wdata1 = 32'h0;
        #1 check32("d1.addr_ok_resp", 32'(addr_ok1), 32'd0);
        @(negedge clk);
        check32("d1.addr_ok_idle", 32'(addr_ok1), 32'd1);
        check32("d1.data_ok_idle", 32'(data_ok1), 32'd0);
        @(negedge clk);
        check32("d1.data_ok_rd", 32'(data_ok1), 32'd1);
        check32("d1.rdata_rd", rdata1, 32'hCAFEF00D);
        req1 = 1'b0;
        @(negedge clk);
`endif

        // Reset during a pending write abandons it.
        txn(1'b1, 4'b1111, 32'h20, 32'h0, 32'h0, 3, "clr20");
        req = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h20; wdata = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #1 rst = 1'b1;
        #1;
        check32("rstmid.addr_ok", 32'(addr_ok), 32'd0);
        check32("rstmid.data_ok", 32'(data_ok), 32'd0);
        check32("rstmid.rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (data_ok !== 1'b0) cnt++;
        end
        check32("rstmid.no_data_ok", 32'(cnt), 32'd0);
        txn(1'b0, 4'b0000, 32'h20, 32'h0, 32'h0, 3, "rd20");

`ifdef DSRAM_RAND_DELAY_EN
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEAABEEF, 0, $sformatf("rand%0d", i));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of word count of the internal memory array.
REQ-002 SHALL have parameter RESP_DELAY, default 1, meaning cycles from address handshake to data_ok; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port data_sram_req, input, 1, request valid from the master.
REQ-006 SHALL have port data_sram_wr, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port data_sram_size, input, 2, access size (0 byte, 1 half, 2 word).
REQ-008 SHALL have port data_sram_wstrb, input, 4, byte-lane write enables.
REQ-009 SHALL have port data_sram_addr, input, 32, byte address.
REQ-010 SHALL have port data_sram_wdata, input, 32, write data, lane-replicated by the master.
REQ-011 SHALL have port data_sram_addr_ok, output, 1, request accepted this cycle.
REQ-012 SHALL have port data_sram_data_ok, output, 1, response valid this cycle (reads and writes).
REQ-013 SHALL have port data_sram_rdata, output, 32, read data, valid only with data_ok.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; exactly one outstanding transaction.
REQ-015 SHALL drive data_sram_addr_ok = data_sram_req in IDLE, 0 in WAIT and RESP (combinational).
REQ-016 SHALL, on handshake (req && addr_ok) at edge T, latch wr, wstrb, addr[DEPTH_LOG2+1:2], wdata; size is not latched.
REQ-017 SHALL transition IDLE->RESP if delay == 1, else IDLE->WAIT with down-counter loaded to delay-1.
REQ-018 SHALL decrement counter each cycle in WAIT; counter == 1 -> RESP.
REQ-019 SHALL assert data_ok for exactly one cycle in RESP, i.e. in cycle T+delay; RESP->IDLE unconditionally.
REQ-020 SHALL for reads drive rdata = full memory word at latched index during RESP; master performs byte/half extraction.
REQ-021 SHALL for writes update only bytes whose latched wstrb bit is 1, at the edge ending RESP; rdata = 0 on write response.
REQ-022 SHALL drive rdata = 0 whenever data_ok = 0.
REQ-023 SHALL ignore address bits above DEPTH_LOG2+1 (wrap-around aliasing) and bits [1:0] for indexing.
REQ-024 SHALL treat wr=1 with wstrb=0 as a legal no-op write that still returns data_ok.
REQ-025 SHALL ignore req/addr/wdata changes while in WAIT or RESP; a req held high through RESP is accepted in the following IDLE cycle (max throughput one transaction per delay+1 cycles).
REQ-026 SHALL make a read of a word written by the immediately preceding transaction return the new data.

Reset
REQ-027 SHALL on rst assertion immediately force state IDLE, counter 0, addr_ok 0 (when req 0), data_ok 0, rdata 0, latched fields 0.
REQ-028 SHALL abandon any in-flight transaction on reset; a pending write is not committed and no data_ok is issued.
REQ-029 SHALL not reset memory array contents.

Configuration
REQ-030 SHALL, with macro DSRAM_RAND_DELAY_EN defined, use per-transaction delay = 1 + lfsr[1:0] (1..4), ignoring RESP_DELAY; lfsr is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, reset to 8'hA5, advancing every cycle, sampled at handshake.
REQ-031 SHALL, without DSRAM_RAND_DELAY_EN, use fixed delay = RESP_DELAY and contain no LFSR.

Verification
REQ-032 Word write addr 0x10 wdata 0xDEADBEEF wstrb 4'b1111, then read 0x10 -> data_ok once per access, rdata 0xDEADBEEF, addr_ok only in IDLE.
REQ-033 Byte write wstrb 4'b0100 wdata 0x00AA0000 to 0x10 over 0xDEADBEEF, read 0x12 -> rdata 0xDEAABEEF.
REQ-034 RESP_DELAY=3, read handshake at edge T -> data_ok high only in cycle T+3; req held high -> next addr_ok at T+4.
REQ-035 DEPTH_LOG2=10, write 0x11223344 to 0x0000_1000, read 0x0000_0000 -> rdata 0x11223344 (aliasing).
REQ-036 rst asserted in WAIT of a write 0x55555555 to 0x20 (prior content 0) -> outputs 0 immediately, no data_ok, later read 0x20 -> 0x00000000.
REQ-037 DSRAM_RAND_DELAY_EN defined, 16 back-to-back reads -> every delay in 1..4, sequence matches LFSR model seeded 8'hA5.
